// File: rtl/core_pkg.sv
// Shared types for the TOY core fetch front end: address/instruction words,
// queue entry layout, and the fetch FSM state encoding.
package core_pkg;

  typedef logic [7:0]  addr_t;
  typedef logic [15:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  localparam addr_t RESET_PC_DEFAULT = 8'h10;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/core_fetch_queue.sv
// Circular instruction queue: pushes up to FETCH_W entries and pops up to
// ISSUE_W entries per cycle; flush_i empties it on the next edge.
module core_fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [$clog2(FETCH_W+1)-1:0]       push_cnt_i,
  input  fetch_entry_t [FETCH_W-1:0]         push_data_i,
  input  logic [$clog2(ISSUE_W+1)-1:0]       pop_cnt_i,
  output fetch_entry_t [ISSUE_W-1:0]         head_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q + AW'(pop_cnt_i);
    tail_d  = tail_q + AW'(push_cnt_i);
    count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(push_cnt_i)) mem_q[tail_q + AW'(i)] <= push_data_i[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < ISSUE_W; j++) head_o[j] = mem_q[head_q + AW'(j)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/core_fetch.sv
// Instruction-fetch front end: group reads from memory lanes into a queue and
// in-order issue to decode. Optional CORE_FETCH_BYPASS_EN gives 0-cycle latency.
module core_fetch
  import core_pkg::*;
#(
  parameter int unsigned FETCH_W     = 2,
  parameter int unsigned ISSUE_W     = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter addr_t       RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               exec_i,
  input  logic                               pc_wen_i,
  input  logic [7:0]                         pc_i,
  output logic [7:0]                         pc_o,
  input  logic                               redirect_i,
  input  logic [7:0]                         redirect_pc_i,
  output logic [FETCH_W-1:0]                 mem_val_o,
  output logic [8*FETCH_W-1:0]               mem_addr_o,
  input  logic [FETCH_W-1:0]                 mem_rdy_i,
  input  logic [16*FETCH_W-1:0]              mem_data_i,
  output logic [ISSUE_W-1:0]                 instr_val_o,
  output logic [16*ISSUE_W-1:0]              instr_data_o,
  output logic [8*ISSUE_W-1:0]               instr_pc_o,
  input  logic [$clog2(ISSUE_W+1)-1:0]       deq_cnt_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count_o,
  output fetch_state_e                       dbg_state_o
);

  localparam int DW = $clog2(ISSUE_W+1);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int PW = $clog2(FETCH_W+1);
  localparam int NW = CW + 2;

  // Handshake: a memory lane transfers when mem_val_o[i] && mem_rdy_i[i]; data
  // is valid in that same cycle and the address is held until the transfer.
  fetch_state_e                state_q, state_d;
  addr_t                       pc_q, pc_d, grp_pc_q, grp_pc_d;
  logic [FETCH_W-1:0]          done_q, done_d, accept;
  instr_t [FETCH_W-1:0]        data_q, data_d;
  fetch_entry_t [FETCH_W-1:0]  grp_entry, push_data;
  fetch_entry_t [ISSUE_W-1:0]  head;
  logic [CW-1:0]               count;
  logic [PW-1:0]               push_cnt;
  logic [DW-1:0]               pop_cnt;
  logic [NW-1:0]               count_next;
  logic                        flush, fetching, grp_done, complete, bypass, space_ok;

  assign flush    = pc_wen_i | redirect_i;
  assign fetching = (state_q == FETCH);
  assign accept   = fetching ? (~done_q & mem_rdy_i) : '0;
  assign grp_done = fetching & (&(done_q | mem_rdy_i));
  assign complete = grp_done & ~flush;

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      grp_entry[i].pc      = grp_pc_q + addr_t'(i);
      grp_entry[i].instr   = done_q[i] ? data_q[i] : mem_data_i[16*i +: 16];
      mem_val_o[i]         = fetching & ~done_q[i];
      mem_addr_o[8*i +: 8] = fetching ? grp_entry[i].pc : '0;
    end
  end

`ifdef CORE_FETCH_BYPASS_EN
  localparam int BYP_W = (FETCH_W < ISSUE_W) ? FETCH_W : ISSUE_W;
  assign bypass = complete && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Occupancy after this edge; a started group always has room reserved.
  assign count_next = NW'(count) + (complete ? NW'(FETCH_W) : '0) - NW'(deq_cnt_i);
  assign space_ok   = (count_next + NW'(FETCH_W)) <= NW'(QUEUE_DEPTH);

  always_comb begin
    push_data = grp_entry;
    push_cnt  = complete ? PW'(FETCH_W) : '0;
    pop_cnt   = deq_cnt_i;
`ifdef CORE_FETCH_BYPASS_EN
    if (bypass) begin
      pop_cnt  = '0;
      push_cnt = PW'(FETCH_W) - PW'(deq_cnt_i);
      for (int i = 0; i < FETCH_W; i++) begin
        push_data[i] = (i + int'(deq_cnt_i) < FETCH_W) ? grp_entry[i + int'(deq_cnt_i)] : '0;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    grp_pc_d = grp_pc_q;
    done_d   = done_q;
    data_d   = data_q;
    if (flush) begin
      state_d = IDLE;
      pc_d    = pc_wen_i ? pc_i : redirect_pc_i;
      done_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (exec_i && space_ok) begin
            state_d  = FETCH;
            grp_pc_d = pc_q;
            done_d   = '0;
          end
        end
        FETCH: begin
          for (int i = 0; i < FETCH_W; i++) begin
            if (accept[i]) data_d[i] = mem_data_i[16*i +: 16];
          end
          done_d = done_q | accept;
          if (grp_done) begin
            pc_d   = pc_q + addr_t'(FETCH_W);
            done_d = '0;
            if (exec_i && space_ok) grp_pc_d = pc_q + addr_t'(FETCH_W);
            else                    state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      grp_pc_q <= RESET_PC;
      done_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      grp_pc_q <= grp_pc_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  core_fetch_queue #(
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_cnt),
    .head_o      (head),
    .count_o     (count)
  );

  for (genvar j = 0; j < ISSUE_W; j++) begin : g_out
    fetch_entry_t out_e;
    logic         out_v;
`ifdef CORE_FETCH_BYPASS_EN
    fetch_entry_t byp_e;
    if (j < FETCH_W) begin : g_byp
      assign byp_e = grp_entry[j];
    end else begin : g_nobyp
      assign byp_e = '0;
    end
    assign out_v = bypass ? (j < BYP_W) : (count > CW'(j));
    assign out_e = bypass ? byp_e : head[j];
`else
    assign out_v = count > CW'(j);
    assign out_e = head[j];
`endif
    assign instr_val_o[j]          = out_v;
    assign instr_data_o[16*j +: 16] = out_v ? out_e.instr : '0;
    assign instr_pc_o[8*j +: 8]     = out_v ? out_e.pc : '0;
  end

  assign pc_o        = pc_q;
  assign q_count_o   = count;
  assign dbg_state_o = state_q;

  // The consumer may never take more instructions than are shown valid.
  always @(posedge clk_i) begin
    if (rst_ni) assert (int'(deq_cnt_i) <= $countones(instr_val_o));
  end

endmodule

// File: tb/tb_core_fetch.sv
// Self-checking bench for core_fetch: directed vector table, hand-written
// corner sequences, and randomized traffic against a sequence-level model.
module tb_core_fetch;
  import core_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int QD = 8;
  localparam int DW = $clog2(IW+1);
  localparam int CW = $clog2(QD+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             exec, pc_wen, redirect;
  logic [7:0]       pc_in, redirect_pc, pc_out;
  logic [FW-1:0]    mem_val, mem_rdy;
  logic [8*FW-1:0]  mem_addr;
  logic [16*FW-1:0] mem_data;
  logic [IW-1:0]    instr_val;
  logic [16*IW-1:0] instr_data;
  logic [8*IW-1:0]  instr_pc;
  logic [DW-1:0]    deq_cnt;
  logic [CW-1:0]    q_count;
  fetch_state_e     dbg_state;

  always #5 clk = ~clk;

  core_fetch #(
    .FETCH_W(FW), .ISSUE_W(IW), .QUEUE_DEPTH(QD), .RESET_PC(8'h10)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .exec_i(exec), .pc_wen_i(pc_wen), .pc_i(pc_in),
    .pc_o(pc_out), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .mem_val_o(mem_val), .mem_addr_o(mem_addr), .mem_rdy_i(mem_rdy),
    .mem_data_i(mem_data), .instr_val_o(instr_val), .instr_data_o(instr_data),
    .instr_pc_o(instr_pc), .deq_cnt_i(deq_cnt), .q_count_o(q_count),
    .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } ent_t;

  typedef struct {
    logic       ex;
    logic [1:0] rdy;
    int         deq;
    logic [7:0] pc;
    logic [1:0] mv;
    int         q;
    logic [1:0] val;
    logic [7:0] pc0;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        exp_q[$];
  logic [7:0]  m_pc;
  logic [FW-1:0] m_done;
  logic [15:0] m_data [FW];
  vec_t        tbl [11];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    logic [7:0] hi;
    hi = a * 8'd3 + 8'h11;
    return {hi, a ^ 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic cycle(input logic ex, input logic [FW-1:0] rdy, input int deq,
                       input logic pw, input logic [7:0] pv,
                       input logic rd, input logic [7:0] rp);
    int         n;
    logic [7:0] a;
    ent_t       e;
    exec = ex; mem_rdy = rdy; deq_cnt = DW'(deq);
    pc_wen = pw; pc_in = pv; redirect = rd; redirect_pc = rp;
    for (int i = 0; i < FW; i++) begin
      a = mem_addr[8*i +: 8];
      mem_data[16*i +: 16] = rdy[i] ? mem_word(a) : 16'($urandom);
    end
    #1;
    n = exp_q.size();
    chk("pc_o", pc_out, m_pc);
    chk("q_count", q_count, n);
    for (int j = 0; j < IW; j++) begin
      chk("instr_val", instr_val[j], j < n);
      if (j < n) begin
        chk("instr_pc", instr_pc[8*j +: 8], exp_q[j].pc);
        chk("instr_data", instr_data[16*j +: 16], exp_q[j].data);
      end
    end
    for (int i = 0; i < FW; i++) begin
      a = m_pc + 8'(i);
      if (mem_val[i]) chk("mem_addr", mem_addr[8*i +: 8], a);
      if (m_done[i])  chk("mem_val_after_done", mem_val[i], 1'b0);
    end
    if (|mem_val) chk("space_reserved", n + FW <= QD, 1'b1);
    if (pw || rd) begin
      exp_q.delete();
      m_done = '0;
      m_pc   = pw ? pv : rp;
    end else begin
      for (int k = 0; k < deq; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      for (int i = 0; i < FW; i++) begin
        if (mem_val[i] && rdy[i]) begin
          m_data[i] = mem_word(mem_addr[8*i +: 8]);
          m_done[i] = 1'b1;
        end
      end
      if (&m_done) begin
        for (int i = 0; i < FW; i++) begin
          e.pc   = m_pc + 8'(i);
          e.data = m_data[i];
          exp_q.push_back(e);
        end
        m_pc   = m_pc + 8'(FW);
        m_done = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic ex, input logic [FW-1:0] rdy, input int deq);
    cycle(ex, rdy, deq, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, dq, f;
    rst_n = 1'b0; exec = 1'b0; pc_wen = 1'b0; redirect = 1'b0;
    pc_in = '0; redirect_pc = '0; mem_rdy = '0; mem_data = '0; deq_cnt = '0;
    m_pc = 8'h10; m_done = '0;

    tbl[0]  = '{1'b1, 2'b11, 0, 8'h10, 2'b00, 0, 2'b00, 8'h00};
    tbl[1]  = '{1'b1, 2'b11, 0, 8'h10, 2'b11, 0, 2'b00, 8'h00};
    tbl[2]  = '{1'b1, 2'b11, 2, 8'h12, 2'b11, 2, 2'b11, 8'h10};
    tbl[3]  = '{1'b1, 2'b11, 2, 8'h14, 2'b11, 2, 2'b11, 8'h12};
    tbl[4]  = '{1'b1, 2'b11, 0, 8'h16, 2'b11, 2, 2'b11, 8'h14};
    tbl[5]  = '{1'b1, 2'b11, 0, 8'h18, 2'b11, 4, 2'b11, 8'h14};
    tbl[6]  = '{1'b1, 2'b11, 0, 8'h1A, 2'b11, 6, 2'b11, 8'h14};
    tbl[7]  = '{1'b1, 2'b11, 0, 8'h1C, 2'b00, 8, 2'b11, 8'h14};
    tbl[8]  = '{1'b1, 2'b11, 2, 8'h1C, 2'b00, 8, 2'b11, 8'h14};
    tbl[9]  = '{1'b1, 2'b11, 0, 8'h1C, 2'b11, 6, 2'b11, 8'h16};
    tbl[10] = '{1'b1, 2'b11, 0, 8'h1E, 2'b00, 8, 2'b11, 8'h16};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_o", pc_out, 8'h10);
    chk("rst_mem_val", mem_val, '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_instr_val", instr_val, '0);
    chk("rst_instr_data", instr_data, '0);
    chk("rst_instr_pc", instr_pc, '0);
    chk("rst_q_count", q_count, '0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // Startup throughput, fill to full, resume once space frees.
    for (int v = 0; v < 11; v++) begin
      chk("tbl_pc_o", pc_out, tbl[v].pc);
      chk("tbl_mem_val", mem_val, tbl[v].mv);
      chk("tbl_q_count", q_count, tbl[v].q);
      chk("tbl_instr_val", instr_val, tbl[v].val);
      if (tbl[v].val[0]) chk("tbl_instr_pc0", instr_pc[7:0], tbl[v].pc0);
      run(tbl[v].ex, tbl[v].rdy, tbl[v].deq);
    end

    // Lane 1 late by three cycles while lane 0 answers at once.
    cycle(1'b1, 2'b11, 0, 1'b1, 8'h30, 1'b0, 8'h00);
    chk("pcw_q_empty", q_count, '0);
    chk("pcw_val", instr_val, '0);
    run(1'b1, 2'b00, 0);
    run(1'b1, 2'b01, 0);
    for (int k = 0; k < 2; k++) begin
      chk("late_mem_val", mem_val, 2'b10);
      chk("late_addr1", mem_addr[15:8], 8'h31);
      chk("late_q_empty", q_count, '0);
      run(1'b1, 2'b01, 0);
    end
    run(1'b1, 2'b11, 0);
    chk("late_q2", q_count, 2);
    chk("late_pc0", instr_pc[7:0], 8'h30);
    chk("late_pc1", instr_pc[15:8], 8'h31);

    // Redirect together with a same-cycle memory accept.
    cycle(1'b1, 2'b11, 0, 1'b0, 8'h00, 1'b1, 8'h40);
    chk("redir_q_empty", q_count, '0);
    chk("redir_val", instr_val, '0);
    chk("redir_pc_o", pc_out, 8'h40);
    chk("redir_mem_val", mem_val, 2'b00);
    run(1'b1, 2'b00, 0);
    chk("redir_addrs", mem_addr, 16'h4140);

    // Manual PC write outranks redirect.
    cycle(1'b1, 2'b11, 0, 1'b1, 8'h20, 1'b1, 8'h40);
    chk("prio_pc_o", pc_out, 8'h20);

    // Address wrap FF -> 00.
    cycle(1'b1, 2'b11, 0, 1'b1, 8'hFF, 1'b0, 8'h00);
    run(1'b1, 2'b11, 0);
    chk("wrap_addrs", mem_addr, 16'h00FF);
    run(1'b0, 2'b11, 0);
    chk("wrap_pc_o", pc_out, 8'h01);
    chk("wrap_instr_pc", instr_pc, 16'h00FF);
    chk("wrap_val", instr_val, 2'b11);

    // Randomized traffic with alternating slow and fast consumers.
    for (int c = 0; c < 1500; c++) begin
      mx = (exp_q.size() < IW) ? exp_q.size() : IW;
      dq = $urandom_range(0, mx);
      if (((c / 100) % 2 == 1) && ($urandom_range(0, 3) != 0)) dq = 0;
      f = $urandom_range(0, 39);
      cycle($urandom_range(0, 9) < 8, FW'($urandom), dq,
            f == 0, 8'($urandom), (f == 1) || (f == 2), 8'($urandom));
    end

    // Asynchronous reset in the middle of traffic.
    exec = 1'b1; mem_rdy = 2'b01; deq_cnt = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_val", mem_val, '0);
    chk("midrst_pc_o", pc_out, 8'h10);
    chk("midrst_q_count", q_count, '0);
    chk("midrst_val", instr_val, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
